// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract: processes a WIDTH-bit operand pair DIGIT bits per clock,
// LSB digit first, rippling the carry between digits through a register.

module serial_addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};
endmodule

module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_param
        $error("serial_addsub: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_sr, b_sr, res_sr, res_next, dsum_ext;
    logic [DIGIT-1:0]  dsum;
    logic              carry, dcarry, msb_cin;
    logic [CW-1:0]     cnt;

    serial_addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a  (a_sr[DIGIT-1:0]),
        .b  (b_sr[DIGIT-1:0]),
        .ci (carry),
        .s  (dsum),
        .co (dcarry)
    );

    always_comb begin
        dsum_ext             = '0;
        dsum_ext[DIGIT-1:0]  = dsum;
    end

    // New digit enters at the top so the last digit lands in the MSB position.
    assign res_next = (res_sr >> DIGIT) | (dsum_ext << (WIDTH - DIGIT));
    // Carry into the MSB recovered from that bit's operands and sum.
    assign msb_cin  = a_sr[DIGIT-1] ^ b_sr[DIGIT-1] ^ dsum[DIGIT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_next;
                    carry  <= dcarry;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum   <= res_next;
                        cout  <= dcarry;
                        ovf   <= msb_cin ^ dcarry;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised, multi-cycle add/subtract unit: successor to the single-bit full adder.
- Processes an N-bit operand pair DIGIT bits per clock, ripple-carrying between digits through a carry register.
- Supports add and subtract-with-borrow, carry/borrow in and out, signed overflow, and a start/done handshake.
- Used where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 1, bits processed per clock (1 = bit-serial, WIDTH = single-cycle datapath).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled at rising clk, accepted only when busy=0
- a  input  WIDTH  operand A; sampled with accepted start
- b  input  WIDTH  operand B; sampled with accepted start
- cin  input  1  carry-in (add) / borrow-in (sub); sampled with accepted start
- sub  input  1  0 = add, 1 = subtract; sampled with accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results are valid
- sum  output  WIDTH  result
- cout  output  1  carry-out (add); NOT borrow, i.e. 1 = no borrow (sub)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers and carry cleared. Reset mid-operation abandons the operation with no done pulse.
- N = WIDTH/DIGIT.
- Arithmetic:
  - add: {cout,sum} = a + b + cin.
  - sub: {cout,sum} = a + ~b + ~cin, i.e. a - b - cin.
  - Carry register initialised to cin when sub=0, ~cin when sub=1.
  - ovf = carry into MSB XOR carry out of MSB.
- States: IDLE, RUN.
- IDLE:
  - busy=0.
  - On an edge with start=1: latch a, b (inverted if sub), and the initial carry.
  - Clear the digit counter to 0 and go to RUN; busy=1 from that edge.
- RUN, one digit per edge, LSB digit first:
  - Digit sum = A_digit + B_digit + carry.
  - Result digit shifts into the result register from the MSB side.
  - Carry register updated; counter increments.
- On the edge processing digit N-1 (the Nth RUN edge):
  - sum, cout, ovf are written.
  - done=1 for exactly one cycle; busy=0; state returns to IDLE.
- Latency: start sampled at edge k, then done high in the cycle after edge k+N and results valid from edge k+N. DIGIT=WIDTH gives 1-cycle latency.
- start while busy=1: ignored; no effect on the in-flight operation or on the next one.
- Back-to-back: start may be high in the same cycle done is high (busy=0). It is accepted at the next edge, giving throughput of one result per N+1 cycles.
- sum, cout, ovf hold their last values until the next completion. They do not change during RUN, because the result shifts in an internal register and is copied on completion.
- a, b, cin, sub may change freely after the start edge.
- done never asserts without a preceding accepted start.

Test Plan:
- WIDTH=16, DIGIT=1: reset then start with a=FFFF, b=0001, cin=0, sub=0 -> done exactly 16 cycles after the start edge; sum=0000, cout=1, ovf=0; busy high for 16 cycles.
- WIDTH=16, DIGIT=4, add: a=7FFF, b=0001, cin=0 -> done after 4 cycles; sum=8000, cout=0, ovf=1. Repeat with cin=1, a=1234, b=4321 -> sum=5556, cout=0, ovf=0.
- WIDTH=16, DIGIT=4, subtract:
  - a=0005, b=0007, cin=0, sub=1 -> sum=FFFE, cout=0, ovf=0.
  - a=8000, b=0001, sub=1 -> sum=7FFF, cout=1, ovf=1.
  - a=0005, b=0005, cin=1 -> sum=FFFF, cout=0.
- Handshake, WIDTH=8, DIGIT=2:
  - Pulse start mid-RUN with different operands -> ignored; result matches the first operands.
  - Hold start high through done -> second operation accepted; done pulses separated by 5 cycles.
- Reset mid-operation: assert rst_n=0 on the 2nd RUN cycle of an 8-cycle operation -> busy, done, sum, cout, ovf = 0 immediately (asynchronously). No done pulse follows; the next start completes correctly.
- WIDTH=4, DIGIT=4, exhaustive loop over all a, b, cin, sub -> every result matches the reference arithmetic above; done 1 cycle after each start.
